// File: rtl/fft_addr_seq.sv
// In-place radix-2 DIT FFT address sequencer.
// Issues one butterfly per cycle (read pair + twiddle index). A shadow shift
// register replays each read pair as the write pair BF_LATENCY cycles later.
// Each stage is followed by a drain period, so every write of a stage lands
// before the next stage starts reading.
module fft_addr_seq #(
  parameter  int N          = 16,
  parameter  int BF_LATENCY = 2,
  localparam int AW         = $clog2(N),
  localparam int SW         = (AW < 2) ? 1 : $clog2(AW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          sel,
  output logic          rd_valid,
  output logic [AW-1:0] read_address1,
  output logic [AW-1:0] read_address2,
  output logic [AW-2:0] twiddle_index,
  output logic [SW-1:0] stage,
  output logic          wr_en,
  output logic [AW-1:0] write_address1,
  output logic [AW-1:0] write_address2
);

  localparam int DW = $clog2(BF_LATENCY + 1);
  localparam int PW = BF_LATENCY * AW;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-2:0] j;
  logic [SW-1:0] stage_r;
  logic [DW-1:0] dcnt;
  logic          last_j, last_drain, last_stage;

  logic [AW-1:0] jx, mask, pos, grp, ra1, ra2, tw_full;
  logic [SW-1:0] tw_sh;

  logic [BF_LATENCY-1:0] vld_p;
  logic [PW-1:0]         wa1_p, wa2_p;

  assign last_j     = (j == {(AW-1){1'b1}});
  assign last_drain = (dcnt == DW'(BF_LATENCY - 1));
  assign last_stage = (stage_r == SW'(AW - 1));

  // FSM state, butterfly index, stage and drain counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      j       <= '0;
      stage_r <= '0;
      dcnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          j       <= '0;
          stage_r <= '0;
          dcnt    <= '0;
        end
        ISSUE: begin
          // j wraps to 0 after the last butterfly, ready for the next stage
          j    <= j + (AW-1)'(1);
          dcnt <= '0;
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (last_drain && !last_stage) stage_r <= stage_r + SW'(1);
        end
        DONE: begin
          stage_r <= '0;
        end
        default: begin
          j <= '0;
        end
      endcase
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    sel       = 1'b0;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        sel      = 1'b1;
        rd_valid = 1'b1;
        if (last_j) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        sel  = 1'b1;
        if (last_drain) state_nxt = last_stage ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        sel       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly address and twiddle arithmetic; outputs forced to 0 when idle
  always_comb begin
    jx      = {1'b0, j};
    mask    = (AW'(1) << stage_r) - AW'(1);
    pos     = jx & mask;
    grp     = jx >> stage_r;
    ra1     = ((grp << stage_r) << 1) | pos;
    ra2     = ra1 + (AW'(1) << stage_r);
    tw_sh   = SW'(AW - 1) - stage_r;
    tw_full = pos << tw_sh;
    stage          = stage_r;
    read_address1  = rd_valid ? ra1 : '0;
    read_address2  = rd_valid ? ra2 : '0;
    twiddle_index  = rd_valid ? tw_full[AW-2:0] : '0;
  end

  // ---- stage boundary: read issue -> write-back shadow pipeline ----
  // Shadow pipeline: replays each read pair as the write pair after BF_LATENCY
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      wa1_p <= '0;
      wa2_p <= '0;
    end else begin
      vld_p <= (vld_p << 1) | BF_LATENCY'(rd_valid);
      wa1_p <= (wa1_p << AW) | PW'(read_address1);
      wa2_p <= (wa2_p << AW) | PW'(read_address2);
    end
  end

  assign wr_en          = vld_p[BF_LATENCY-1];
  assign write_address1 = wa1_p[PW-1 -: AW];
  assign write_address2 = wa2_p[PW-1 -: AW];

endmodule

// File: doc/fft_addr_seq.md
# fft_addr_seq

In-place radix-2 DIT FFT sequencer driving the dual-port complex intermediate RAM (`cRAM`). Per stage, it generates the butterfly operand pair read addresses and the twiddle-factor index. It delays those addresses through a shadow pipeline matching the butterfly latency so results are written back to the same locations. It owns the RAM (`sel`) while running and separates stages with a drain period to avoid read-after-write hazards.

## Interface
Parameters:
- `N`, default 16: FFT points; power of two, N ≥ 4; equals RAM depth.
- `BF_LATENCY`, default 2: butterfly pipeline depth in cycles from RAM read data to write data; must be ≥ 1.

Widths:
- AW = $clog2(N).
- SW = max(1, $clog2(AW)).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: start request; sampled in IDLE only.
- `busy` out 1: high in ISSUE and DRAIN.
- `done` out 1: one-cycle pulse at completion.
- `sel` out 1: RAM ownership; high from ISSUE through DONE.
- `rd_valid` out 1: read addresses valid this cycle (ISSUE).
- `read_address1` out AW: butterfly top operand address.
- `read_address2` out AW: butterfly bottom operand address.
- `twiddle_index` out AW-1: twiddle ROM index k for W_N^k.
- `stage` out SW: current stage 0..AW-1.
- `wr_en` out 1: write strobe, aligned with the butterfly output.
- `write_address1` out AW: write address for the top result.
- `write_address2` out AW: write address for the bottom result.

## Operation
- Input data is in bit-reversed order in the RAM before `start`. Loading is outside this block, done while `sel` = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `start` = 1 → ISSUE with stage = 0, j = 0.
  - ISSUE: emits one butterfly per cycle, j = 0..N/2−1. After j = N/2−1 → DRAIN.
  - DRAIN: lasts BF_LATENCY cycles.
    - Afterwards, if stage < AW−1 → ISSUE with stage+1, j = 0.
    - Else → DONE.
  - DONE: one cycle → IDLE.
- Address arithmetic, with half = 2^stage, pos = j mod half, grp = j >> stage:
  - read_address1 = grp·2·half + pos
  - read_address2 = read_address1 + half
  - twiddle_index = pos << (AW−1−stage)
  - All are computed combinationally from registered j and stage; no overflow is possible within range.
- Write pipeline: a BF_LATENCY-deep shift register carries {rd_valid, read_address1, read_address2}. Its output drives {wr_en, write_address1, write_address2}.
- The shift register keeps shifting in DRAIN, DONE and IDLE with valid = 0. All writes of a stage therefore land before the first read of the next stage.
- `start` outside IDLE is ignored; there is no queueing.
- `rst` in any state:
  - The FSM returns to IDLE on the next edge.
  - j, stage and all pipeline valid bits clear.
  - No further `wr_en` is issued; any in-flight butterflies are discarded.

## Timing
- Reset values: `busy`, `done`, `sel`, `rd_valid` and `wr_en` are 0; `stage`, j, all addresses and `twiddle_index` are 0.
- `start` sampled high at edge E0 → ISSUE begins in the cycle after E0 (cycle 1).
  - `rd_valid` = 1 with addresses for j = 0, stage 0.
- Read is combinational in RAM. `wr_en` for a butterfly issued in cycle c is high in cycle c + BF_LATENCY, carrying that butterfly's addresses.
- Per stage: N/2 ISSUE cycles, then BF_LATENCY DRAIN cycles.
- `done` is high in cycle AW·(N/2 + BF_LATENCY) + 1. For N = 16, BF_LATENCY = 2, that is cycle 41. `busy` falls in the same cycle.
- The last `wr_en` occurs in the final DRAIN cycle, before DONE.
- `sel` falls the cycle after `done`.
- Back-to-back operation: `start` held high in the IDLE cycle after DONE starts a new transform.

## Test plan
All scenarios use N = 16, BF_LATENCY = 2.
- Stage 0 addressing: `start` pulse → cycles 1..8 give read pairs (0,1), (2,3) … (14,15), each with `twiddle_index` 0. `wr_en` is high in cycles 3..10 with the same pairs.
- Stage 1/3 addressing:
  - Stage 1, j = 1 (cycle 12) → (1,3), twiddle 4.
  - Stage 3, j = 5 → (5,13), twiddle 5.
  - Stage 3, j = 7 → (7,15), twiddle 7.
- Hazard/drain: for every stage, the last `wr_en` cycle precedes the next stage's first `rd_valid` cycle. `rd_valid` is 0 in cycles 9–10.
- Completion: `done` is a single pulse in cycle 41; `busy` is 0 from cycle 41; total `wr_en` count = 32; `sel` is 0 in cycle 42.
- Ignored start: `start` re-asserted in cycle 20 → no restart; `done` still in cycle 41.
- Mid-run reset: `rst` in cycle 15 → from cycle 16, `busy`/`wr_en`/`sel` = 0 and `stage` = 0. A new `start` then completes normally 41 cycles later.
